// File: rtl/forward_car_safety_controller.sv
// Safety controller for a 1-D forward-driving car: vets accel/coast/brake requests against a
// stopping-distance bound to a fixed obstacle. Define FORWARD_CAR_SAFETY_ASSERT_EN for checks.
module forward_car_safety_controller #(
    parameter real         VMAX  = 5.0,
    parameter int unsigned DWELL = 3,
    parameter int unsigned CW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  real           nondet_A,
    input  real           nondet_B,
    input  real           nondet_m,
    input  logic          req_valid,
    input  logic [1:0]    req_choice,
    output logic          req_ready,
    input  real           x_in,
    input  real           v_in,
    output real           a_out,
    output logic          a_valid,
    output logic          override,
    output logic [CW-1:0] override_cnt,
    output logic [1:0]    state_out
);

    localparam int unsigned DwW = (DWELL > 1) ? $clog2(DWELL + 1) : 1;

    typedef enum logic [1:0] {
        StInit      = 2'b00,
        StRun       = 2'b01,
        StBrakeHold = 2'b10,
        StStopped   = 2'b11
    } state_e;

    state_e         state_q;
    logic [DwW-1:0] dwell_q;
    real            a_q;
    real            b_q;
    real            m_q;

    real           s_accel;
    real           s_coast;
    logic          inputs_ok;
    logic          accel_safe;
    logic          coast_safe;
    logic          accept;
    logic          is_accel;
    logic [CW-1:0] cnt_inc;

    // Finite means the IEEE-754 exponent field is not all ones (rules out NaN and +/-Inf).
    function automatic logic is_finite(input real r);
        logic [63:0] bits;
        bits = $realtobits(r);
        return bits[62:52] != 11'h7FF;
    endfunction

    function automatic real sample_or(input real r, input real dflt);
        return (is_finite(r) && (r > 0.0)) ? r : dflt;
    endfunction

    assign req_ready = (state_q == StRun) || (state_q == StStopped);
    assign state_out = state_q;
    assign accept    = req_valid && req_ready;
    assign is_accel  = (req_choice == 2'b00);
    assign cnt_inc   = (override_cnt == {CW{1'b1}}) ? override_cnt : override_cnt + CW'(1);

    // S(u) = u*u/B + u, the conservative distance needed to stop from speed u.
    always_comb begin
        inputs_ok  = is_finite(x_in) && is_finite(v_in);
        s_accel    = (v_in + a_q) * (v_in + a_q) / b_q + (v_in + a_q);
        s_coast    = v_in * v_in / b_q + v_in;
        accel_safe = inputs_ok && (v_in <= VMAX) && (x_in + v_in + s_accel <= m_q);
        coast_safe = inputs_ok && (x_in + v_in + s_coast <= m_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= sample_or(nondet_A, 0.1);
            b_q          <= sample_or(nondet_B, 0.1);
            m_q          <= sample_or(nondet_m, 100.0);
            a_out        <= 0.0;
            a_valid      <= 1'b0;
            override     <= 1'b0;
            override_cnt <= '0;
            dwell_q      <= '0;
            state_q      <= StInit;
        end else begin
            a_valid  <= 1'b0;
            override <= 1'b0;
            unique case (state_q)
                StInit: state_q <= StRun;
                StRun, StStopped: begin
                    if (accept) begin
                        a_valid <= 1'b1;
                        if (req_choice[1]) begin
                            // Braking while already stopped just holds zero.
                            a_out <= (state_q == StStopped) ? 0.0 : -b_q;
                        end else if (is_accel && accel_safe) begin
                            a_out   <= a_q;
                            state_q <= StRun;
                        end else if (coast_safe) begin
                            a_out    <= 0.0;
                            override <= is_accel;
                            if (is_accel) begin
                                override_cnt <= cnt_inc;
                            end
                            state_q <= StRun;
                        end else begin
                            a_out        <= -b_q;
                            override     <= 1'b1;
                            override_cnt <= cnt_inc;
                            dwell_q      <= DwW'(DWELL);
                            state_q      <= StBrakeHold;
                        end
                    end else if ((state_q == StRun) && (v_in == 0.0) && (a_out == -b_q)) begin
                        state_q <= StStopped;
                    end
                end
                StBrakeHold: begin
                    a_out   <= -b_q;
                    dwell_q <= dwell_q - DwW'(1);
                    if (dwell_q <= DwW'(1)) begin
                        state_q <= (v_in == 0.0) ? StStopped : StRun;
                    end
                end
            endcase
        end
    end

`ifdef FORWARD_CAR_SAFETY_ASSERT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (a_out == a_q || a_out == 0.0 || a_out == -b_q);
            if (state_q != StInit) begin
                assert (x_in <= m_q);
                assert (v_in >= 0.0);
            end
            assert (!((state_q == StBrakeHold) && req_ready));
            assert (!override || a_valid);
        end
    end
`endif

endmodule

// File: doc/forward_car_safety_controller.md
Name: forward_car_safety_controller

Overview:
- Controller-side counterpart to the 1-D forward-driving car plant.
- Accepts acceleration requests (accelerate / coast / brake) over a valid/ready handshake.
- Checks each request against a conservative discrete-time stopping-distance bound to a fixed obstacle, then issues the safe acceleration to the plant.
- Feeds the plant's `a` input and reads back the plant's position `x` and velocity `v`; the formal RNM harness closes the loop.

Parameters:
- VMAX, 5.0, real: velocity ceiling above which accelerate is refused.
- DWELL, 3, minimum cycles held in BRAKE_HOLD after a forced brake (>=1).
- CW, 8, width of the override counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- nondet_A  in  real  candidate max acceleration, sampled in reset
- nondet_B  in  real  candidate max braking, sampled in reset
- nondet_m  in  real  candidate obstacle position, sampled in reset
- req_valid  in  1  request present
- req_choice  in  2  00 = accel, 01 = coast, 1x = brake
- req_ready  out  1  controller can accept a request
- x_in  in  real  plant position
- v_in  in  real  plant velocity
- a_out  out  real  commanded acceleration
- a_valid  out  1  one-cycle pulse: a_out updated from an accepted request
- override  out  1  one-cycle pulse with a_valid: request was replaced by a safer command
- override_cnt  out  CW  saturating count of overrides
- state_out  out  2  00 = INIT, 01 = RUN, 10 = BRAKE_HOLD, 11 = STOPPED

Behaviour:
- Reset (rst = 1, every cycle it is held):
  - A <= nondet_A if >0, not NaN, not Inf; else 0.1. Same rule for B. m <= nondet_m under the same rule, else 100.0.
  - a_out = 0.0, a_valid = 0, override = 0, override_cnt = 0, req_ready = 0, state = INIT.
  - A, B and m hold until the next reset.
- INIT: one cycle, then go to RUN and set req_ready = 1. NaN/Inf on x_in or v_in is treated as unsafe: force brake.
- Bound: S(u) = u*u/B + u, evaluated with real arithmetic.
  - Accel safe iff v_in <= VMAX and x_in + v_in + S(v_in + A) <= m.
  - Coast safe iff x_in + v_in + S(v_in) <= m.
- Acceptance: req_valid && req_ready on edge k. The command is decided combinationally from x_in/v_in sampled at edge k. a_out, a_valid and override are registered and visible after edge k (latency 1).
- Decision in RUN:
  - Accel safe -> A.
  - Accel requested but unsafe, coast safe -> 0.0, override.
  - Otherwise -B. If the request was not brake: override, load dwell counter with DWELL, go to BRAKE_HOLD.
  - Brake request -> -B, no override.
- No accepted request: a_out holds its value, a_valid = 0.
- BRAKE_HOLD:
  - req_ready = 0 and a_out = -B.
  - Counter decrements each cycle. At 0, go to RUN, or to STOPPED if v_in == 0.0.
- STOPPED:
  - req_ready = 1. Brake requests output 0.0; these are not overrides.
  - Accel or coast accepted under the RUN rules -> RUN.
- Entry to STOPPED from RUN: any cycle with v_in == 0.0 and a_out == -B.
- override_cnt: increments on each override pulse; saturates at 2^CW-1 with no wrap.
- Reset mid-operation (including mid-dwell): all state returns to reset values on that edge; A, B and m are resampled.
- Simultaneous events: dwell expiry and a new req_valid on the same edge -> the request is not accepted, since req_ready was 0 that cycle.

Optional Feature:
- Macro: FORWARD_CAR_SAFETY_ASSERT_EN.
- When defined, the following embedded properties are compiled in:
  - a_out is always one of {A, 0.0, -B}.
  - Outside rst/INIT: x_in <= m, and v_in >= 0.0.
  - req_ready is never 1 in BRAKE_HOLD.
  - override implies a_valid.
- When undefined: no assertions; functional behaviour is identical.

Test Plan:
- Reset with nondet_A = -1.0, nondet_B = NaN, nondet_m = Inf -> A = 0.1, B = 0.1, m = 100.0; all outputs at reset values; state RUN two cycles after rst falls.
- A = 1.0, B = 2.0, m = 100.0, x = 0, v = 2; accel request -> next cycle a_out = 1.0, a_valid = 1, override = 0.
- Same settings, v = 6.0; accel request -> a_out = 0.0 (VMAX exceeded, coast safe since 0+6+18+6 <= 100); override = 1; override_cnt = 1.
- x = 90, v = 4, B = 2, m = 100; coast request -> a_out = -2.0, override = 1; BRAKE_HOLD for 3 cycles with req_ready = 0 and requests ignored.
- v_in = 0 at dwell expiry -> STOPPED; brake request -> a_out = 0.0, no override; accel with x = 0, m = 100 -> a_out = A, state RUN.
- 300 consecutive forced overrides with CW = 8 -> override_cnt stops at 255; rst asserted mid-dwell -> counter 0 and state INIT on the next edge.
